// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous ROM (1-cycle registered
// read) among NREQ level-requesters, with a two-stage tag pipeline routing
// each returned word to the requester that issued it.
//
// Ports:
//   clk       - single clock, all state on rising edge
//   rst_n     - asynchronous active-low reset
//   req       - level request per requester (bit i = requester i)
//   req_addr  - requester i address at [AW*i +: AW]
//   gnt       - one-hot grant, registered, one cycle per granted read
//   rvalid    - one-hot read-data-valid, registered, 2 cycles after gnt
//   rdata     - shared read data, meaningful while any rvalid bit is high
//   rom_en    - ROM enable, registered
//   rom_addr  - ROM address, registered, holds when idle
//   rom_data  - ROM read data, valid one cycle after rom_en/rom_addr sampled

module rom_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               rom_en,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Tag carried alongside each issued read.
    typedef struct packed {
        logic          vld;
        logic [PW-1:0] id;
    } tag_t;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;
    logic          found;
    logic [PW:0]   sum;
    tag_t          s1;
    tag_t          s2;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] k);
        logic [NREQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first asserted req at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            if (!found && req[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_nxt = win + 1'b1;
        if (win == PW'(NREQ - 1)) begin
            ptr_nxt = '0;
        end
    end

    // Issue stage: grant, ROM request and stage-1 tag all move together,
    // so s1 is aligned with rom_en/rom_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            ptr      <= '0;
            s1       <= '0;
        end else if (found) begin
            gnt      <= onehot(win);
            rom_en   <= 1'b1;
            rom_addr <= req_addr[AW*win +: AW];
            ptr      <= ptr_nxt;
            s1       <= '{vld: 1'b1, id: win};
        end else begin
            gnt      <= '0;
            rom_en   <= 1'b0;
            s1       <= '0;
        end
    end

    // Return stage: s2 lines up with rom_data; rdata is only loaded when a
    // tracked read returns, so idle-cycle ROM output never reaches rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2     <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            s2 <= s1;
            if (s2.vld) begin
                rvalid <= onehot(s2.id);
                rdata  <= rom_data;
            end else begin
                rvalid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vector table, hand sequences for reset corners,
// and a randomized phase checked against a queue-based reference model.

module tb_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_addr = '0;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [3:0]  rdata;
    logic        rom_en;
    logic [3:0]  rom_addr;
    logic [3:0]  rom_data = '0;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] rom_key = '0;

    rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_val(input logic [3:0] a);
        return a ^ rom_key;
    endfunction

    // Synchronous ROM; garbage on its output whenever it was not enabled.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_val(rom_addr);
        else        rom_data <= 4'($urandom);
    end

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp_v, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] addr;
        logic [3:0]  gnt;
        logic [3:0]  rvalid;
        logic [3:0]  rdata;
        logic        rom_en;
        logic [3:0]  rom_addr;
    } vec_t;

    vec_t tbl[22];

    // Reference model state
    typedef struct {
        int         id;
        logic [3:0] data;
        int         due;
    } rd_t;

    rd_t        q[$];
    int         m_ptr;
    int         m_cyc;
    logic [3:0] m_gnt;
    logic [3:0] m_rvalid;
    logic [3:0] m_rdata;
    logic       m_rom_en;
    logic [3:0] m_rom_addr;

    task automatic model_reset();
        q.delete();
        m_ptr      = 0;
        m_cyc      = 0;
        m_gnt      = '0;
        m_rvalid   = '0;
        m_rdata    = '0;
        m_rom_en   = 1'b0;
        m_rom_addr = '0;
    endtask

    task automatic model_step();
        rd_t e;
        int  w;
        m_cyc++;
        m_rvalid = '0;
        if (q.size() > 0 && q[0].due == m_cyc) begin
            e        = q.pop_front();
            m_rvalid = 4'b1 << e.id;
            m_rdata  = e.data;
        end
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (w < 0 && req[j]) w = j;
        end
        if (w >= 0) begin
            m_gnt      = 4'b1 << w;
            m_rom_en   = 1'b1;
            m_rom_addr = req_addr[4*w +: 4];
            m_ptr      = (w + 1) % NREQ;
            e.id       = w;
            e.data     = rom_val(req_addr[4*w +: 4]);
            e.due      = m_cyc + 2;
            q.push_back(e);
        end else begin
            m_gnt    = '0;
            m_rom_en = 1'b0;
        end
    endtask

    initial begin
        logic [3:0]  pend;
        logic [15:0] paddr;

        //        req      addr      gnt      rvalid  rd  en  ra
        tbl[0]  = '{4'b1111, 16'hC973, 4'b0001, 4'b0000, 4'h0, 1'b1, 4'h3};
        tbl[1]  = '{4'b1111, 16'hC973, 4'b0010, 4'b0000, 4'h0, 1'b1, 4'h7};
        tbl[2]  = '{4'b1111, 16'hC973, 4'b0100, 4'b0001, 4'h3, 1'b1, 4'h9};
        tbl[3]  = '{4'b1111, 16'hC973, 4'b1000, 4'b0010, 4'h7, 1'b1, 4'hC};
        tbl[4]  = '{4'b1111, 16'hC973, 4'b0001, 4'b0100, 4'h9, 1'b1, 4'h3};
        tbl[5]  = '{4'b0000, 16'hC973, 4'b0000, 4'b1000, 4'hC, 1'b0, 4'h3};
        tbl[6]  = '{4'b0000, 16'h0000, 4'b0000, 4'b0001, 4'h3, 1'b0, 4'h3};
        tbl[7]  = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h3, 1'b0, 4'h3};
        tbl[8]  = '{4'b0001, 16'h0005, 4'b0001, 4'b0000, 4'h3, 1'b1, 4'h5};
        tbl[9]  = '{4'b0000, 16'h0005, 4'b0000, 4'b0000, 4'h3, 1'b0, 4'h5};
        tbl[10] = '{4'b0000, 16'h0000, 4'b0000, 4'b0001, 4'h5, 1'b0, 4'h5};
        tbl[11] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h5, 1'b0, 4'h5};
        tbl[12] = '{4'b0100, 16'h0900, 4'b0100, 4'b0000, 4'h5, 1'b1, 4'h9};
        tbl[13] = '{4'b1001, 16'hC003, 4'b1000, 4'b0000, 4'h5, 1'b1, 4'hC};
        tbl[14] = '{4'b0001, 16'hC003, 4'b0001, 4'b0100, 4'h9, 1'b1, 4'h3};
        tbl[15] = '{4'b0000, 16'h0000, 4'b0000, 4'b1000, 4'hC, 1'b0, 4'h3};
        tbl[16] = '{4'b0000, 16'h0000, 4'b0000, 4'b0001, 4'h3, 1'b0, 4'h3};
        tbl[17] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h3, 1'b0, 4'h3};
        tbl[18] = '{4'b0010, 16'h00B0, 4'b0010, 4'b0000, 4'h3, 1'b1, 4'hB};
        tbl[19] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h3, 1'b0, 4'hB};
        tbl[20] = '{4'b0000, 16'h0000, 4'b0000, 4'b0010, 4'hB, 1'b0, 4'hB};
        tbl[21] = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'hB, 1'b0, 4'hB};

        // Reset state, then the directed table.
        do_reset();
        check("rst_gnt", 16'(gnt), 16'h0);
        check("rst_rvalid", 16'(rvalid), 16'h0);
        check("rst_rdata", 16'(rdata), 16'h0);
        check("rst_rom_en", 16'(rom_en), 16'h0);
        check("rst_rom_addr", 16'(rom_addr), 16'h0);

        for (int i = 0; i < 22; i++) begin
            req      = tbl[i].req;
            req_addr = tbl[i].addr;
            cyc();
            check($sformatf("v%0d_gnt", i), 16'(gnt), 16'(tbl[i].gnt));
            check($sformatf("v%0d_rvalid", i), 16'(rvalid),
                  16'(tbl[i].rvalid));
            check($sformatf("v%0d_rdata", i), 16'(rdata),
                  16'(tbl[i].rdata));
            check($sformatf("v%0d_rom_en", i), 16'(rom_en),
                  16'(tbl[i].rom_en));
            check($sformatf("v%0d_rom_addr", i), 16'(rom_addr),
                  16'(tbl[i].rom_addr));
        end

        // Asynchronous reset mid-cycle with traffic in flight.
        do_reset();
        req      = 4'b1111;
        req_addr = 16'hC973;
        repeat (3) cyc();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", 16'(gnt), 16'h0);
        check("async_rvalid", 16'(rvalid), 16'h0);
        check("async_rdata", 16'(rdata), 16'h0);
        check("async_rom_en", 16'(rom_en), 16'h0);
        check("async_rom_addr", 16'(rom_addr), 16'h0);
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        repeat (3) begin
            cyc();
            check("rel_gnt", 16'(gnt), 16'h0);
            check("rel_rvalid", 16'(rvalid), 16'h0);
            check("rel_rom_en", 16'(rom_en), 16'h0);
        end

        // Reset pulse while two reads are in flight.
        do_reset();
        req      = 4'b1111;
        req_addr = 16'hC973;
        cyc();
        cyc();
        req = '0;
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            cyc();
            check("flight_rvalid", 16'(rvalid), 16'h0);
            check("flight_gnt", 16'(gnt), 16'h0);
        end
        req = 4'b1111;
        cyc();
        check("flight_regnt", 16'(gnt), 16'h1);
        check("flight_readdr", 16'(rom_addr), 16'h3);
        req = '0;
        cyc();
        cyc();
        check("flight_rv", 16'(rvalid), 16'h1);
        check("flight_rd", 16'(rdata), 16'h3);

        // Randomized traffic against the reference model.
        rom_key = 4'h6;
        do_reset();
        model_reset();
        pend  = '0;
        paddr = '0;
        for (int k = 0; k < 400; k++) begin
            req      = pend;
            req_addr = paddr;
            if (k == 200) begin
                #1;
                rst_n = 1'b0;
                model_reset();
                #2;
                rst_n = 1'b1;
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("rnd_gnt", 16'(gnt), 16'(m_gnt));
            check("rnd_rvalid", 16'(rvalid), 16'(m_rvalid));
            check("rnd_rdata", 16'(rdata), 16'(m_rdata));
            check("rnd_rom_en", 16'(rom_en), 16'(m_rom_en));
            check("rnd_rom_addr", 16'(rom_addr), 16'(m_rom_addr));
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && m_gnt[i]) begin
                    pend[i] = ($urandom_range(3) == 0);
                    if (pend[i]) paddr[4*i +: 4] = 4'($urandom);
                end else if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i]         = 1'b1;
                    paddr[4*i +: 4] = 4'($urandom);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4 for this release.
REQ-002 Parameter AW, default 4, ROM address width.
REQ-003 Parameter DW, default 4, ROM data width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  level request per requester; bit i = requester i.
REQ-007 req_addr  input  NREQ*AW  requester i address at bits [AW*i+AW-1 : AW*i].
REQ-008 gnt  output  NREQ  one-hot grant, registered.
REQ-009 rvalid  output  NREQ  one-hot read-data-valid, registered.
REQ-010 rdata  output  DW  read data, shared bus, meaningful only while any rvalid bit is high.
REQ-011 rom_en  output  1  ROM enable, registered.
REQ-012 rom_addr  output  AW  ROM address, registered.
REQ-013 rom_data  input  DW  ROM registered read data, valid one cycle after rom_en/rom_addr are sampled.

Function
REQ-014 The block SHALL share one synchronous ROM (1-cycle registered read) among NREQ requesters, issuing at most one ROM read per cycle.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer ptr and proceeds upward modulo NREQ; first asserted req bit wins.
REQ-016 On a win by requester w at edge E0, after E0: gnt = one-hot(w), rom_en = 1, rom_addr = req_addr of w, ptr = (w+1) mod NREQ.
REQ-017 With no req bit asserted at an edge: gnt = 0, rom_en = 0, rom_addr holds its previous value, ptr unchanged.
REQ-018 Each gnt pulse SHALL last exactly one cycle per granted read.
REQ-019 A requester SHALL hold req and its address until it sees gnt; req still asserted at the edge ending the gnt cycle counts as a new request.
REQ-020 Pipeline: a 2-stage tag pipeline (valid, requester id) SHALL track each issued read; stage 1 aligns with rom_en, stage 2 with rom_data.
REQ-021 For a grant at edge E0, at edge E0+2: rdata = rom_data, rvalid = one-hot(w) for one cycle (latency gnt -> rvalid = 2 cycles).
REQ-022 Back-to-back grants SHALL produce back-to-back rvalid pulses in grant order, with no bubbles and no data reordering.
REQ-023 When no read returns, rvalid = 0 and rdata SHALL hold its last value; rom_data (possibly X while rom_en was low) SHALL never be captured into rdata.
REQ-024 A requester SHALL receive at most one grant in any NREQ consecutive grant cycles while other requesters are continuously requesting.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) clear gnt, rvalid, rdata, rom_en, rom_addr to 0, ptr to 0 and both pipeline valid bits to 0.
REQ-026 Reads in flight at reset assertion SHALL be discarded: no rvalid for them after release.
REQ-027 The first edge after rst_n deasserts SHALL arbitrate normally from ptr = 0.

Verification
REQ-028 Reset: drive rst_n low mid-cycle with req = 4'b1111 -> all outputs 0 without waiting for clk; release with req = 0 -> rom_en stays 0, gnt/rvalid stay 0.
REQ-029 Single read: req = 4'b0001, requester 0 addr = 5, ROM holding mem[a] = a -> gnt = 4'b0001 and rom_addr = 5 one cycle later; rvalid = 4'b0001 with rdata = 5 two cycles after gnt.
REQ-030 Full load: req = 4'b1111 held, addrs 3/7/9/12 for requesters 0..3 -> gnt sequence 0,1,2,3,0,... one per cycle; rvalid back-to-back with rdata 3,7,9,12,3,...
REQ-031 Pointer: after a grant to requester 2 (ptr = 3), assert req = 4'b1001 -> requester 3 granted first, then requester 0.
REQ-032 Reset mid-flight: two reads granted in consecutive cycles, rst_n pulsed low before either rvalid -> no rvalid after release; next grant follows ptr = 0 order.
REQ-033 Single access: requester 1 deasserts req in its gnt cycle -> exactly one gnt and one rvalid for requester 1.
